// File: rtl/variable_shift_left_serial.sv
// Bit-serial variable left shifter / rotator.
// Moves the captured operand one bit position per clock through a single
// 1-bit shift stage, then presents the result with a one-cycle done pulse.
// In logical mode OV flags any 1 bit that fell off the top.
module variable_shift_left_serial #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             data_start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shift_width,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted_a,
  output logic             OV
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    cnt;
  logic             ov_acc;
  logic             mode;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: launch on data_start in IDLE, return once cnt runs out.
  // NOTE: the default is assigned first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (data_start) state_next = SHIFT;
      SHIFT:   if (cnt == '0)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one-position shift per cycle, result publish.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      work      <= '0;
      cnt       <= '0;
      ov_acc    <= 1'b0;
      mode      <= 1'b0;
      done      <= 1'b0;
      shifted_a <= '0;
      OV        <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (data_start) begin
        work   <= a;
        cnt    <= shift_width;
        mode   <= rotate;
        ov_acc <= 1'b0;
      end
    end else begin
      if (cnt != '0) begin
        if (mode) begin
          // Rotate: the MSB re-enters at the bottom, nothing is lost.
          work <= {work[WIDTH-2:0], work[WIDTH-1]};
        end else begin
          work   <= {work[WIDTH-2:0], 1'b0};
          ov_acc <= ov_acc | work[WIDTH-1];
        end
        cnt <= cnt - 1'b1;
      end else begin
        // Done is raised on the same edge the FSM returns to IDLE, so a new
        // start can be accepted while done is still high.
        shifted_a <= work;
        OV        <= ov_acc;
        done      <= 1'b1;
      end
    end
  end

  // Busy is a plain decode of the state register.
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_variable_shift_left_serial.sv
// Self-checking bench for variable_shift_left_serial: directed corner cases,
// an exhaustive logical sweep and a randomized mixed-mode run, all compared
// against an arithmetic reference model.
module tb_variable_shift_left_serial;

  localparam int WIDTH = 8;
  localparam int SW    = 3;

  logic             clk;
  logic             Reset;
  logic             data_start;
  logic [WIDTH-1:0] a;
  logic [SW-1:0]    shift_width;
  logic             rotate;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shifted_a;
  logic             OV;

  int n_checks = 0;
  int n_pass   = 0;

  variable_shift_left_serial #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .data_start (data_start),
    .a          (a),
    .shift_width(shift_width),
    .rotate     (rotate),
    .busy       (busy),
    .done       (done),
    .shifted_a  (shifted_a),
    .OV         (OV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {ov, result}. Computed in a 16-bit field: the low byte is the
  // truncated left shift, the high byte holds whatever overflowed.
  function automatic logic [8:0] model(input logic [7:0] op, input int n, input logic rot);
    logic [15:0] wide;
    logic [7:0]  res;
    logic        ov;
    if (rot) begin
      wide = {op, op} << n;
      res  = wide[15:8];
      ov   = 1'b0;
    end else begin
      wide = {8'h00, op} << n;
      res  = wide[7:0];
      ov   = |wide[15:8];
    end
    return {ov, res};
  endfunction

  // Present an operation at the falling edge; the next rising edge accepts it.
  task automatic pulse_start(input logic [7:0] op, input int n, input logic rot);
    @(negedge clk);
    a           = op;
    shift_width = SW'(n);
    rotate      = rot;
    data_start  = 1'b1;
    @(posedge clk);
    #1;
    data_start = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled 1 time unit after the edge).
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input logic [7:0] op, input int n, input logic rot, input string tag);
    logic [8:0] exp;
    int         c;
    exp = model(op, n, rot);
    pulse_start(op, n, rot);
    check({tag, "_busy"}, 16'(busy), 16'd1);
    wait_done(20, c);
    check({tag, "_latency"}, 16'(c), 16'(n + 1));
    check({tag, "_result"}, 16'(shifted_a), 16'(exp[7:0]));
    check({tag, "_ov"}, 16'(OV), 16'(exp[8]));
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 16'(done), 16'd0);
  endtask

  initial begin
    logic [8:0] exp;
    int         c;
    int         dones;
    logic [7:0] r_a;
    int         r_n;
    logic       r_rot;

    Reset       = 1'b0;
    data_start  = 1'b0;
    a           = '0;
    shift_width = '0;
    rotate      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check("reset_result", 16'(shifted_a), 16'd0);
    check("reset_ov", 16'(OV), 16'd0);
    @(negedge clk);
    Reset = 1'b1;

    // Directed corner cases.
    run_op(8'h01, 3, 1'b0, "d_01_n3");
    check("d_01_n3_const", 16'(shifted_a), 16'h08);
    run_op(8'h81, 1, 1'b0, "d_81_lsl");
    check("d_81_lsl_ov_const", 16'(OV), 16'd1);
    run_op(8'h81, 1, 1'b1, "d_81_rol");
    check("d_81_rol_const", 16'(shifted_a), 16'h03);
    run_op(8'hFF, 7, 1'b0, "d_ff_n7");
    check("d_ff_n7_const", 16'(shifted_a), 16'h80);
    run_op(8'h5A, 0, 1'b0, "d_5a_n0");
    check("d_5a_n0_const", 16'(shifted_a), 16'h5A);
    run_op(8'hC3, 7, 1'b1, "d_c3_rol7");

    // A start while busy must be ignored.
    exp = model(8'h13, 5, 1'b0);
    pulse_start(8'h13, 5, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    a           = 8'hFF;
    shift_width = 3'd1;
    rotate      = 1'b1;
    data_start  = 1'b1;
    @(posedge clk);
    #1;
    data_start = 1'b0;
    wait_done(20, c);
    check("busy_ignore_latency", 16'(c), 16'd4);
    check("busy_ignore_result", 16'(shifted_a), 16'(exp[7:0]));
    check("busy_ignore_ov", 16'(OV), 16'(exp[8]));

    // Start on the done cycle: accepted back-to-back.
    exp         = model(8'hA5, 2, 1'b1);
    a           = 8'hA5;
    shift_width = 3'd2;
    rotate      = 1'b1;
    data_start  = 1'b1;
    @(posedge clk);
    #1;
    data_start = 1'b0;
    check("b2b_done_low", 16'(done), 16'd0);
    check("b2b_busy", 16'(busy), 16'd1);
    wait_done(20, c);
    check("b2b_latency", 16'(c), 16'd3);
    check("b2b_result", 16'(shifted_a), 16'(exp[7:0]));
    check("b2b_ov", 16'(OV), 16'(exp[8]));
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("no_extra_done", 16'(dones), 16'd0);

    // Reset mid-operation aborts with everything cleared.
    pulse_start(8'hF0, 6, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_result", 16'(shifted_a), 16'd0);
    check("abort_ov", 16'(OV), 16'd0);
    @(negedge clk);
    Reset = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("abort_quiet", 16'(dones), 16'd0);

    // Exhaustive logical sweep over every operand and shift amount.
    for (int n = 0; n < 8; n++) begin
      for (int v = 0; v < 256; v++) begin
        exp = model(8'(v), n, 1'b0);
        pulse_start(8'(v), n, 1'b0);
        wait_done(20, c);
        check("sweep_latency", 16'(c), 16'(n + 1));
        check("sweep_result", 16'(shifted_a), 16'(exp[7:0]));
        check("sweep_ov", 16'(OV), 16'(exp[8]));
        @(posedge clk);
        #1;
      end
    end

    // Randomized mixed-mode operations.
    for (int i = 0; i < 300; i++) begin
      r_a   = 8'($urandom);
      r_n   = int'($urandom_range(0, 7));
      r_rot = 1'($urandom);
      run_op(r_a, r_n, r_rot, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
